tqvp_dlmiles_i2c_errdet: RTL and testbench

- I2C bus-line monitor and error detector that produces the one-cycle error strobes (TIMEOUT, IO, GENERIC) consumed by the peripheral's interrupt/error state unit.
- Samples raw SCL/SDA pins and compares them with the controller's drive intent.
- Tracks START/STOP, bus-busy state and SCL-low duration.
- Sits between the pad inputs and the interrupt/error unit, alongside the I2C controller FSM.

---
 rtl/tqvp_dlmiles_i2c_errdet.sv | 195 +++++++++++++++++++
 tb/tb_tqvp_dlmiles_i2c_errdet.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_dlmiles_i2c_errdet.sv
// I2C bus-line monitor and error detector.
// Synchronizes raw SCL/SDA, detects START/STOP, tracks bus ownership and SCL-low time,
// and emits one-cycle {TIMEOUT, IO, GENERIC} error strobes.
// Optional: define I2C_ERRDET_GLITCH_FILTER_EN to add a 3-sample stability filter after
// each synchronizer (2 extra cycles of latency, rejects 1-2 cycle pulses).
module tqvp_dlmiles_i2c_errdet #(
  parameter int unsigned SYNC_STAGES   = 2,  // minimum 2
  parameter int unsigned TIMEOUT_WIDTH = 16,
  parameter int unsigned SETTLE_CYCLES = 2   // 0..7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     scl_i,
  input  logic                     sda_i,
  input  logic                     scl_drive_low_i,
  input  logic                     sda_drive_low_i,
  input  logic                     xfer_active_i,
  input  logic                     gen_cond_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit_i,
  output logic [2:0]               stb_error_o,
  output logic                     start_o,
  output logic                     stop_o,
  output logic                     bus_busy_o
);

  typedef enum logic {StIdle, StBusy} bus_state_e;
  typedef enum logic [1:0] {StWaitRise, StSettle, StCheck} io_state_e;

  localparam logic [2:0] SettleLoad = 3'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 1);

  logic [SYNC_STAGES-1:0]   r_scl_sync, r_sda_sync;
  logic                     w_scl_sync, w_sda_sync;
  logic                     w_scl_s, w_sda_s;
  logic                     r_scl_prev, r_sda_prev;
  logic                     w_scl_rise, w_scl_fall, w_start, w_stop;
  bus_state_e               r_bus_state;
  io_state_e                r_io_state;
  logic [2:0]               r_settle_cnt;
  logic [TIMEOUT_WIDTH-1:0] r_to_cnt, w_to_cnt_inc;
  logic                     r_to_fired, w_to_hit;
  logic                     w_do_check, w_io_err, w_gen_err;
  logic [2:0]               r_stb;
  logic                     r_start, r_stop;
  logic                     w_unused;

  // Pin synchronizers; reset to idle-high bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign w_scl_sync = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_sync = r_sda_sync[SYNC_STAGES-1];

`ifdef I2C_ERRDET_GLITCH_FILTER_EN
  logic r_scl_h1, r_scl_h2, r_scl_filt;
  logic r_sda_h1, r_sda_h2, r_sda_filt;

  // Pass a new level only once it has been seen on three consecutive cycles
  assign w_scl_s = (w_scl_sync == r_scl_h1 && r_scl_h1 == r_scl_h2) ? w_scl_sync : r_scl_filt;
  assign w_sda_s = (w_sda_sync == r_sda_h1 && r_sda_h1 == r_sda_h2) ? w_sda_sync : r_sda_filt;

  // Sample history and held filter output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_h1   <= 1'b1;
      r_scl_h2   <= 1'b1;
      r_scl_filt <= 1'b1;
      r_sda_h1   <= 1'b1;
      r_sda_h2   <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_h1   <= w_scl_sync;
      r_scl_h2   <= r_scl_h1;
      r_scl_filt <= w_scl_s;
      r_sda_h1   <= w_sda_sync;
      r_sda_h2   <= r_sda_h1;
      r_sda_filt <= w_sda_s;
    end
  end
`else
  assign w_scl_s = w_scl_sync;
  assign w_sda_s = w_sda_sync;
`endif

  // Previous-sample registers for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl_s;
      r_sda_prev <= w_sda_s;
    end
  end

  assign w_scl_rise = w_scl_s & ~r_scl_prev;
  assign w_scl_fall = ~w_scl_s & r_scl_prev;
  assign w_start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;

  // Bus ownership FSM, independent of enable_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_state <= StIdle;
    end else begin
      unique case (r_bus_state)
        StIdle:  if (w_start) r_bus_state <= StBusy;
        StBusy:  if (w_stop && !w_start) r_bus_state <= StIdle;
        default: r_bus_state <= StIdle;
      endcase
    end
  end

  assign bus_busy_o = (r_bus_state == StBusy);

  // SCL-low timer: one strobe per low episode, re-armed only when SCL goes high
  assign w_to_cnt_inc = (&r_to_cnt) ? r_to_cnt : r_to_cnt + TIMEOUT_WIDTH'(1);
  assign w_to_hit     = enable_i && !w_scl_s && !r_to_fired && (timeout_limit_i != '0) &&
                        (w_to_cnt_inc == timeout_limit_i);

  // Timer counter and fired flag, held cleared while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt   <= '0;
      r_to_fired <= 1'b0;
    end else if (!enable_i || w_scl_s) begin
      r_to_cnt   <= '0;
      r_to_fired <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_inc;
      if (w_to_hit) r_to_fired <= 1'b1;
    end
  end

  // SDA comparator FSM: wait SETTLE_CYCLES after an SCL rise, then compare once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_state   <= StWaitRise;
      r_settle_cnt <= '0;
    end else begin
      unique case (r_io_state)
        StWaitRise: begin
          if (w_scl_rise && SETTLE_CYCLES == 1) begin
            r_io_state <= StCheck;
          end else if (w_scl_rise && SETTLE_CYCLES > 1) begin
            r_io_state   <= StSettle;
            r_settle_cnt <= SettleLoad;
          end
        end
        StSettle: begin
          if (w_scl_fall)              r_io_state <= StWaitRise;
          else if (r_settle_cnt <= 3'd1) r_io_state <= StCheck;
          else                         r_settle_cnt <= r_settle_cnt - 3'd1;
        end
        StCheck: r_io_state <= StWaitRise;
        default: r_io_state <= StWaitRise;
      endcase
    end
  end

  // With zero settle time the compare happens on the rise cycle itself
  assign w_do_check = (r_io_state == StCheck) ||
                      (SETTLE_CYCLES == 0 && r_io_state == StWaitRise && w_scl_rise);
  assign w_io_err   = w_do_check && xfer_active_i &&
                      (sda_drive_low_i ? w_sda_s : !w_sda_s);
  assign w_gen_err  = (w_start || w_stop) && xfer_active_i && !gen_cond_i;

  // SCL stretching by other devices is legal, so controller SCL intent raises no error
  assign w_unused = scl_drive_low_i;

  // Registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb   <= 3'b000;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_stb   <= enable_i ? {w_to_hit, w_io_err, w_gen_err} : 3'b000;
      r_start <= w_start;
      r_stop  <= w_stop;
    end
  end

  assign stb_error_o = r_stb;
  assign start_o     = r_start;
  assign stop_o      = r_stop;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_errdet.sv
// Scoreboard bench for tqvp_dlmiles_i2c_errdet: a behavioural model predicts every output
// cycle into a queue, a monitor process pops and compares on each cycle.
module tb_tqvp_dlmiles_i2c_errdet;
  localparam int SS = 2;
  localparam int TW = 16;
  localparam int SC = 2;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b1;
  logic          scl_i = 1'b1;
  logic          sda_i = 1'b1;
  logic          scl_drive_low_i = 1'b0;
  logic          sda_drive_low_i = 1'b0;
  logic          xfer_active_i = 1'b0;
  logic          gen_cond_i = 1'b0;
  logic [TW-1:0] timeout_limit_i = '0;
  logic [2:0]    stb_error_o;
  logic          start_o, stop_o, bus_busy_o;

  tqvp_dlmiles_i2c_errdet #(
    .SYNC_STAGES  (SS),
    .TIMEOUT_WIDTH(TW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .scl_i          (scl_i),
    .sda_i          (sda_i),
    .scl_drive_low_i(scl_drive_low_i),
    .sda_drive_low_i(sda_drive_low_i),
    .xfer_active_i  (xfer_active_i),
    .gen_cond_i     (gen_cond_i),
    .timeout_limit_i(timeout_limit_i),
    .stb_error_o    (stb_error_o),
    .start_o        (start_o),
    .stop_o         (stop_o),
    .bus_busy_o     (bus_busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_to = 0, n_io = 0, n_gen = 0, n_start = 0, n_stop = 0;
  bit model_on = 0, mon_on = 0;
  logic [5:0] exp_q[$];

  // Reference model state: pin history plus abstract bus facts
  bit m_scl_h[$], m_sda_h[$];
  int m_k, m_cnt, m_pend_at;
  bit m_prev_scl, m_prev_sda, m_busy, m_fired, m_pend, m_fscl, m_fsda;

  task automatic model_clear();
    m_scl_h.delete(); m_sda_h.delete();
    m_k = 0; m_cnt = 0; m_pend_at = 0;
    m_prev_scl = 1; m_prev_sda = 1; m_busy = 0; m_fired = 0; m_pend = 0;
    m_fscl = 1; m_fsda = 1;
  endtask

  // Pin level as seen through the synchronizer; before reset release the bus reads idle-high
  function automatic bit raw_at(bit is_sda, int idx);
    if (idx < 0) return 1'b1;
    return is_sda ? m_sda_h[idx] : m_scl_h[idx];
  endfunction

  task automatic model_step();
    bit s_scl, s_sda, st, sp, to_e, io_e, gen_e, chk;
    int idx;
    idx = m_k - SS;
`ifdef I2C_ERRDET_GLITCH_FILTER_EN
    if (raw_at(0, idx) == raw_at(0, idx - 1) && raw_at(0, idx - 1) == raw_at(0, idx - 2))
      m_fscl = raw_at(0, idx);
    if (raw_at(1, idx) == raw_at(1, idx - 1) && raw_at(1, idx - 1) == raw_at(1, idx - 2))
      m_fsda = raw_at(1, idx);
    s_scl = m_fscl;
    s_sda = m_fsda;
`else
    s_scl = raw_at(0, idx);
    s_sda = raw_at(1, idx);
`endif
    st = s_scl && m_prev_scl && m_prev_sda && !s_sda;
    sp = s_scl && m_prev_scl && !m_prev_sda && s_sda;
    gen_e = (st || sp) && xfer_active_i && !gen_cond_i;
    to_e = 0;
    if (!enable_i || s_scl) begin
      m_cnt = 0;
      m_fired = 0;
    end else begin
      if (m_cnt < TMAX) m_cnt++;
      if (timeout_limit_i != 0 && m_cnt == int'(timeout_limit_i) && !m_fired) begin
        to_e = 1;
        m_fired = 1;
      end
    end
    chk = 0;
    if (m_pend) begin
      if (m_k == m_pend_at) begin
        chk = 1;
        m_pend = 0;
      end else if (!s_scl && m_prev_scl) begin
        m_pend = 0;
      end
    end else if (s_scl && !m_prev_scl) begin
      if (SC == 0) chk = 1;
      else begin
        m_pend = 1;
        m_pend_at = m_k + SC;
      end
    end
    io_e = chk && xfer_active_i && (sda_drive_low_i ? s_sda : !s_sda);
    if (st) m_busy = 1;
    else if (sp) m_busy = 0;
    exp_q.push_back({enable_i ? {to_e, io_e, gen_e} : 3'b000, st, sp, m_busy});
    m_scl_h.push_back(scl_i);
    m_sda_h.push_back(sda_i);
    m_prev_scl = s_scl;
    m_prev_sda = s_sda;
    m_k++;
  endtask

  // Model evaluates with the inputs the DUT sees at this edge
  always @(posedge clk) begin
    if (model_on) model_step();
  end

  // Monitor: compare every presented output cycle against the scoreboard
  always @(negedge clk) begin
    logic [5:0] e, a;
    if (mon_on) begin
      a = {stb_error_o, start_o, stop_o, bus_busy_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got=%b", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t got stb/start/stop/busy=%b required=%b", $time, a, e);
        end
      end
      if (stb_error_o[2]) n_to++;
      if (stb_error_o[1]) n_io++;
      if (stb_error_o[0]) n_gen++;
      if (start_o) n_start++;
      if (stop_o) n_stop++;
    end
  end

  task automatic check(string name, int got, int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    mon_on = 0;
    model_on = 0;
    rst_n = 0;
    #1;
    check("reset_outputs", int'({stb_error_o, start_o, stop_o, bus_busy_o}), 0);
    exp_q.delete();
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_on = 1;
    #1 mon_on = 1;
  endtask

  initial begin
    int b_to, b_io, b_gen, b_st, b_sp, r;
    model_clear();
    apply_reset();
    tick(5);

    // START then STOP, no transfer in progress
    b_st = n_start; b_sp = n_stop; b_gen = n_gen;
    sda_i = 0; tick(6);
    check("start_pulse", n_start - b_st, 1);
    check("busy_after_start", int'(bus_busy_o), 1);
    sda_i = 1; tick(6);
    check("stop_pulse", n_stop - b_sp, 1);
    check("busy_after_stop", int'(bus_busy_o), 0);
    check("no_generic_idle", n_gen - b_gen, 0);

    // TIMEOUT: two stuck-low episodes, one strobe each
    timeout_limit_i = 100;
    b_to = n_to;
    scl_i = 0; tick(300);
    check("timeout_episode1", n_to - b_to, 1);
    scl_i = 1; tick(10);
    scl_i = 0; tick(300);
    scl_i = 1; tick(10);
    check("timeout_episode2", n_to - b_to, 2);
    timeout_limit_i = 0;

    // IO: arbitration loss flagged, controller-driven low is fine
    xfer_active_i = 1; gen_cond_i = 1;
    b_io = n_io;
    scl_i = 0; tick(3);
    sda_i = 0; sda_drive_low_i = 0; tick(4);
    scl_i = 1; tick(8);
    check("io_arb_lost", n_io - b_io, 1);
    scl_i = 0; tick(4);
    sda_drive_low_i = 1; scl_i = 1; tick(8);
    check("io_driven_low_ok", n_io - b_io, 1);
    scl_i = 0; tick(4);
    sda_i = 1; sda_drive_low_i = 0; tick(3);
    scl_i = 1; tick(8);
    check("io_released_high_ok", n_io - b_io, 1);

    // GENERIC: unexpected STOP mid-transfer, then expected START/STOP
    b_gen = n_gen;
    gen_cond_i = 1; sda_i = 0; tick(6);
    gen_cond_i = 0; sda_i = 1; tick(6);
    check("generic_on_stop", n_gen - b_gen, 1);
    gen_cond_i = 1; sda_i = 0; tick(6);
    sda_i = 1; tick(6);
    check("generic_gen_cond", n_gen - b_gen, 1);

    // Disabled: no strobes, bus tracking continues
    enable_i = 0; gen_cond_i = 0; timeout_limit_i = 20;
    b_to = n_to; b_gen = n_gen;
    scl_i = 0; tick(60);
    scl_i = 1; tick(4);
    sda_i = 0; tick(6);
    check("busy_while_disabled", int'(bus_busy_o), 1);
    sda_i = 1; tick(6);
    check("no_strobe_disabled", (n_to - b_to) + (n_gen - b_gen), 0);
    enable_i = 1; xfer_active_i = 0; tick(4);

    // Async reset while the bus is busy
    sda_i = 0; tick(6);
    check("busy_before_reset", int'(bus_busy_o), 1);
    apply_reset();
    sda_i = 1; tick(8);

`ifdef I2C_ERRDET_GLITCH_FILTER_EN
    b_st = n_start;
    sda_i = 0; tick(2); sda_i = 1; tick(10);
    check("glitch_2cyc_rejected", n_start - b_st, 0);
    sda_i = 0; tick(5); sda_i = 1; tick(10);
    check("glitch_5cyc_passes", n_start - b_st, 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) scl_i = ~scl_i;
      else if (r < 65) sda_i = ~sda_i;
      if ($urandom_range(0, 9) == 0) xfer_active_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) gen_cond_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) sda_drive_low_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) scl_drive_low_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) enable_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) timeout_limit_i = TW'($urandom_range(0, 30));
      if (r >= 96) tick(40);
      else tick($urandom_range(1, 8));
    end
    tick(10);
    check("scoreboard_drained", exp_q.size() <= 1 ? 1 : 0, 1);

    mon_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
